// File: rtl/bcd_pkg.sv
// Shared types and constants for the digit-serial BCD adder.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DIGIT_W  = 4;
  localparam int BCD_MAX  = 9;
  localparam int BCD_CORR = 6;

  function automatic logic digit_over_max(input logic [DIGIT_W-1:0] d);
    return (d > 4'(BCD_MAX));
  endfunction

endpackage

// File: rtl/bcd_serial_adder_if.sv
// Start/done handshake and operand/result bus of the serial BCD adder.
interface bcd_serial_adder_if #(parameter int DIGITS = 4);

  logic                  start;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  cin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   sum;
  logic                  cout;
  logic                  invalid;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, invalid
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, invalid
  );

endinterface

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder with decimal carry in/out.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               c,
  output logic [DIGIT_W-1:0] digit,
  output logic               carry
);

  logic [DIGIT_W:0] t_s;

  // Binary sum, then +6 correction when the digit overflows decimal range
  always_comb begin
    t_s   = {1'b0, a} + {1'b0, b} + {4'b0000, c};
    digit = t_s[DIGIT_W-1:0];
    carry = 1'b0;
    if (t_s > 5'(BCD_MAX)) begin
      digit = t_s[DIGIT_W-1:0] + 4'(BCD_CORR);
      carry = 1'b1;
    end else begin
      digit = t_s[DIGIT_W-1:0];
      carry = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial multi-digit BCD adder, LSD first, start/done handshake.
// Optional operand range check enabled by defining BCD_INVALID_CHECK_EN.
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  bcd_serial_adder_if.slave  bus
);

  localparam int W     = DIGIT_W * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  state_e               state_r;
  state_e               state_s;
  logic [IDX_W-1:0]     idx_r;
  logic [W-1:0]         a_r;
  logic [W-1:0]         b_r;
  logic [W-1:0]         sum_r;
  logic                 carry_r;
  logic                 cout_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 accept_s;
  logic                 step_s;
  logic                 last_s;
  logic [DIGIT_W-1:0]   a_dig_s;
  logic [DIGIT_W-1:0]   b_dig_s;
  logic [DIGIT_W-1:0]   digit_s;
  logic                 carry_s;

  // Current digit pair selected by the index counter
  always_comb begin
    a_dig_s = a_r[idx_r*DIGIT_W +: DIGIT_W];
    b_dig_s = b_r[idx_r*DIGIT_W +: DIGIT_W];
  end

  bcd_digit_add u_digit (
    .a     (a_dig_s),
    .b     (b_dig_s),
    .c     (carry_r),
    .digit (digit_s),
    .carry (carry_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and datapath strobes
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    step_s   = 1'b0;
    last_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          accept_s = 1'b1;
          state_s  = ADD;
        end else begin
          state_s  = IDLE;
        end
      end
      ADD: begin
        step_s = 1'b1;
        if (idx_r == IDX_LAST) begin
          last_s  = 1'b1;
          state_s = DONE;
        end else begin
          state_s = ADD;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Operand latch, digit loop, result and handshake registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      idx_r   <= '0;
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else if (accept_s) begin
      a_r     <= bus.a;
      b_r     <= bus.b;
      carry_r <= bus.cin;
      sum_r   <= '0;
      idx_r   <= '0;
      cout_r  <= 1'b0;
      busy_r  <= 1'b1;
      done_r  <= 1'b0;
    end else if (step_s) begin
      sum_r[idx_r*DIGIT_W +: DIGIT_W] <= digit_s;
      carry_r <= carry_s;
      if (last_s) begin
        idx_r  <= '0;
        cout_r <= carry_s;
        done_r <= 1'b1;
      end else begin
        idx_r  <= idx_r + 1'b1;
      end
    end else if (state_r == DONE) begin
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      carry_r <= 1'b0;
    end else begin
      done_r  <= 1'b0;
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;

`ifdef BCD_INVALID_CHECK_EN
  logic invalid_r;

  function automatic logic any_over(input logic [W-1:0] v);
    logic res;
    res = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      res = res | digit_over_max(v[i*DIGIT_W +: DIGIT_W]);
    end
    return res;
  endfunction

  // Range flag captured with the operands and held until the next start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      invalid_r <= 1'b0;
    end else if (accept_s) begin
      invalid_r <= any_over(bus.a) | any_over(bus.b);
    end else begin
      invalid_r <= invalid_r;
    end
  end

  assign bus.invalid = invalid_r;
`else
  assign bus.invalid = 1'b0;
`endif

endmodule
